lfsr_checker_mc: RTL

Multi-channel, parametrised PRBS/LFSR checker for heater and link-soak designs. Each channel self-synchronises to an incoming LFSR word stream and declares lock after a run of correct words. Once locked, it counts word errors with saturation and drops lock after a run of consecutive misses. Replaces the single-lane, unqualified-data checker: adds a valid qualifier, a lock state machine, error counters and a software clear.

---
 rtl/lfsr_chk_pkg.sv | 31 +++
 rtl/lfsr_checker_lane.sv | 151 +++++++++++++++
 rtl/lfsr_checker_mc.sv | 60 ++++++
 3 files changed

// File: rtl/lfsr_chk_pkg.sv
// Shared definitions for the multi-channel LFSR checker.
//   lock_state_t  : per-lane lock FSM state (HUNT / LOCKED)
//   LFSR_MAX_W    : widest LFSR word lfsr_next() can handle
//   DEFAULT_POLY  : x^32 + x^22 + x^2 + x + 1 tap mask
//   lfsr_next()   : next word of a Fibonacci LFSR, width given at call time
package lfsr_chk_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  localparam int LFSR_MAX_W = 64;

  localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

  // next(d) = {d[width-2:0], ^(d & poly)}, computed at LFSR_MAX_W bits and
  // masked back to 'width' so one function serves every lane width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] data,
    input logic [LFSR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
    fb   = ^(data & poly & mask);
    return ((data << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker_lane.sv
// One checker lane: prediction/compare stage, lock FSM and error counter.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   clear          synchronous pulse: zero err_count and err only
//   valid, datain  qualified LFSR word
//   state          lock FSM state (debug view; LOCKED drives 'locked' at top)
//   err            sticky error flag
//   err_count      saturating count of mismatches seen while LOCKED
//
// Handshake: valid is a pure qualifier with no ready/back-pressure. A word is
// consumed on every clock edge where valid=1; cycles with valid=0 are ignored
// entirely, so gaps in the stream are transparent.
//
// Timing: a word sampled at edge N is compared there and the result is
// registered (beat_q/hit_q/zero_q); the FSM and counters act on it at edge N+1.
module lfsr_checker_lane
  import lfsr_chk_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
  parameter int               LOCK_CNT = 16,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] datain,
  output lock_state_t      state,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

  // ---------------------------------------------------------------- compare
  logic [WIDTH-1:0] pred_q;
  logic             pred_valid_q;
  logic [WIDTH-1:0] pred_next;
  logic             beat_q;   // a valid word arrived with a prediction to test
  logic             hit_q;    // that word equalled the prediction
  logic             zero_q;   // that word was all-zero

  // The prediction always re-seeds from the latest word, so a lane
  // resynchronises by itself after any corruption.
  assign pred_next = WIDTH'(lfsr_next(LFSR_MAX_W'(datain), LFSR_MAX_W'(POLY), WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      beat_q       <= 1'b0;
      hit_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      beat_q <= valid && pred_valid_q;
      hit_q  <= (datain == pred_q);
      zero_q <= (datain == '0);
      if (valid) begin
        pred_q       <= pred_next;
        pred_valid_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- lock FSM
  lock_state_t       state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_evt = 1'b0;
    if (beat_q) begin
      case (state_q)
        HUNT: begin
          // All-zero is the LFSR lock-up word: it predicts itself, so it must
          // never build up a lock.
          if (hit_q && !zero_q) begin
            if (run_q == RUN_LAST) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (hit_q) begin
            miss_d = '0;
          end else begin
            err_evt = 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // clear takes effect first; an error on the same edge still counts.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = err_evt ? CNT_W'(1) : '0;
      err_d = err_evt;
    end else if (err_evt) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: rtl/lfsr_checker_mc.sv
// Multi-channel PRBS/LFSR checker: CHANNELS independent lanes that each
// self-synchronise to an LFSR word stream, lock after LOCK_CNT matches and
// count errors while locked.
// Ports:
//   clk        single clock
//   reset      asynchronous active-high reset
//   clear      synchronous pulse: zero err_count and err on every lane
//   valid      per-lane data qualifier
//   datain     lane n at [n*WIDTH +: WIDTH]
//   locked     lane n is in LOCKED
//   err        sticky per-lane error flag
//   err_any    OR of err
//   err_count  saturating per-lane count, lane n at [n*CNT_W +: CNT_W]
// WIDTH must lie in 8..LFSR_MAX_W.
module lfsr_checker_mc
  import lfsr_chk_pkg::*;
#(
  parameter int               CHANNELS = 4,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
  parameter int               LOCK_CNT = 16,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS*WIDTH-1:0] datain,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS-1:0]       err,
  output logic                      err_any,
  output logic [CHANNELS*CNT_W-1:0] err_count
);

  lock_state_t lane_state [CHANNELS];

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    lfsr_checker_lane #(
      .WIDTH    (WIDTH),
      .POLY     (POLY),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .CNT_W    (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .valid     (valid[n]),
      .datain    (datain[n*WIDTH +: WIDTH]),
      .state     (lane_state[n]),
      .err       (err[n]),
      .err_count (err_count[n*CNT_W +: CNT_W])
    );
    assign locked[n] = (lane_state[n] == LOCKED);
  end

  assign err_any = |err;

endmodule
